// File: rtl/sid_bus_sequencer.sv
// SID register-write engine.
// Generates phi2 from the system clock, runs the chip hardware-reset
// sequence, and plays queued register writes onto a shared SID bus with one
// active-low chip select per chip.
module sid_bus_sequencer #(
    parameter int CLK_DIV      = 8,
    parameter int NUM_CHIPS    = 2,
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 16,
    parameter int CHIP_W       = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1,
    parameter int LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CHIP_W-1:0]    wr_chip,
    input  logic [4:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 sid_rst_req,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 err_chip,
    output logic                 sid_clk,
    output logic                 sid_notres,
    output logic [NUM_CHIPS-1:0] sid_notcs,
    output logic [4:0]           sid_addr,
    output logic [7:0]           sid_data
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [CHIP_W-1:0] chip;
        logic [4:0]        addr;
        logic [7:0]        data;
    } wr_req_t;

    typedef enum logic [1:0] {INIT, IDLE, STROBE, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [DIV_W-1:0]       div_cnt, div_nxt;
    logic [RC_W-1:0]        rst_cnt, rst_cnt_nxt;
    logic                   notres_nxt;
    logic [NUM_CHIPS-1:0]   notcs_nxt;
    logic [4:0]             addr_nxt;
    logic [7:0]             data_nxt;
    logic                   boundary, push, pop, err_set;

    wr_req_t                mem [DEPTH];
    wr_req_t                head;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;

    assign boundary = (div_cnt == DIV_LAST);
    assign div_nxt  = boundary ? '0 : div_cnt + 1'b1;
    assign head     = mem[rd_ptr];
    assign wr_ready = (state != INIT) && (fifo_level < LVL_FULL);
    assign busy     = (state != IDLE) || (fifo_level != '0);
    assign push     = wr_valid && wr_ready;

    // Next-state and bus-output decode; a reset request overrides everything
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        notres_nxt  = sid_notres;
        notcs_nxt   = sid_notcs;
        addr_nxt    = sid_addr;
        data_nxt    = sid_data;
        pop         = 1'b0;
        err_set     = 1'b0;
        case (state)
            INIT: begin
                notcs_nxt  = '1;
                notres_nxt = 1'b0;
                if (boundary) begin
                    if (rst_cnt == RC_LAST) begin
                        notres_nxt  = 1'b1;
                        rst_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                    end
                end
            end
            IDLE: begin
                // Launch on the boundary so address/data/CS are valid at div_cnt==0
                if (boundary && fifo_level != '0) begin
                    pop = 1'b1;
                    if (int'(head.chip) < NUM_CHIPS) begin
                        addr_nxt  = head.addr;
                        data_nxt  = head.data;
                        for (int i = 0; i < NUM_CHIPS; i++)
                            notcs_nxt[i] = (head.chip != CHIP_W'(i));
                        state_nxt = STROBE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            STROBE: begin
                if (boundary)
                    state_nxt = HOLD;
            end
            HOLD: begin
                // One extra clk of CS past the phi2 falling edge, then release
                notcs_nxt = '1;
                state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
        if (sid_rst_req) begin
            state_nxt   = INIT;
            notcs_nxt   = '1;
            notres_nxt  = 1'b0;
            rst_cnt_nxt = '0;
            pop         = 1'b0;
            err_set     = 1'b0;
        end
    end

    // Divider, FSM, bus registers, error flag and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            sid_clk    <= 1'b0;
            state      <= INIT;
            rst_cnt    <= '0;
            sid_notres <= 1'b0;
            sid_notcs  <= '1;
            sid_addr   <= '0;
            sid_data   <= '0;
            err_chip   <= 1'b0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            div_cnt    <= div_nxt;
            sid_clk    <= (div_nxt >= DIV_HALF);
            state      <= state_nxt;
            rst_cnt    <= rst_cnt_nxt;
            sid_notres <= notres_nxt;
            sid_notcs  <= notcs_nxt;
            sid_addr   <= addr_nxt;
            sid_data   <= data_nxt;
            if (err_set)
                err_chip <= 1'b1;
            else if (err_clr)
                err_chip <= 1'b0;
            if (sid_rst_req) begin
                fifo_level <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    fifo_level <= fifo_level + 1'b1;
                else if (pop && !push)
                    fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // FIFO storage; entries need no reset since the pointers gate them
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{chip: wr_chip, addr: wr_addr, data: wr_data};
    end

endmodule
